// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, asynchronous instruction-memory address,
// and the IF/ID pipeline register presented to decode through a valid/ready handshake.
// Handles backpressure stalls, redirects (flush), and stopping on a halt opcode.
module fetch_stage #(
    parameter int unsigned     PC_WIDTH          = 32,
    parameter int unsigned     INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]          RESET_PC  = '0,
    parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSN = 32'h0010_0073,
    parameter int unsigned     CNT_WIDTH         = 32
) (
    input  logic                         clk,
    input  logic                         rstN,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instr,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_target,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic                         halted,
    output logic [CNT_WIDTH-1:0]         fetch_count
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } state_t;

    state_t                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  capture;
    logic                  is_halt;

    // Next-PC candidates, capture decision and halt-word detection.
    always_comb begin
        pc_plus4    = pc_q + PC_WIDTH'(4);
        // Redirect targets are word aligned; low two bits are ignored.
        redirect_pc = {redirect_target[PC_WIDTH-1:2], 2'b00};
        capture     = (state_q == StRun) && !redirect_valid && (!out_valid || out_ready);
        is_halt     = (imem_instr == HALT_INSN);
        imem_addr   = pc_q;
    end

    // FSM, PC and IF/ID register; redirect beats capture beats drain beats stall.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            // Flush wins even if decode is accepting this cycle.
            pc_q      <= redirect_pc;
            out_valid <= 1'b0;
            state_q   <= StRun;
            halted    <= 1'b0;
        end else if (capture) begin
            out_instr   <= imem_instr;
            out_pc      <= pc_q;
            out_valid   <= 1'b1;
            fetch_count <= fetch_count + CNT_WIDTH'(1);
            if (is_halt) begin
                // Halt word is forwarded once; the PC parks on it.
                state_q <= StHalt;
                halted  <= 1'b1;
            end else begin
                pc_q <= pc_plus4;
            end
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Boot lasts exactly one cycle after reset release.
            if (state_q == StBoot) begin
                state_q <= StRun;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, halt, PC wrap and async reset.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'h0010_0073;

    logic        clk;
    logic        rstN;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic        halt_en;
    int          err_cnt;
    int          chk_cnt;

    fetch_stage dut (
        .clk             (clk),
        .rstN            (rstN),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: tagged address words, optional halt word at 0x10.
    always_comb begin
        if (halt_en && imem_addr == 32'h10) imem_instr = HALT;
        else                                imem_instr = 32'h1000_0000 | imem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        err_cnt         = 0;
        chk_cnt         = 0;
        halt_en         = 1'b0;
        rstN            = 1'b0;
        out_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;

        // T1 reset and boot
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        rstN = 1'b1;
        check("boot_addr", imem_addr, 32'd0);
        step();                                 // boot edge, no capture
        check("boot_valid", 32'(out_valid), 32'd0);
        check("boot_count", fetch_count, 32'd0);
        check("run_addr", imem_addr, 32'd0);
        step();
        check("t1_pc0", out_pc, 32'h0);
        check("t1_instr0", out_instr, 32'h1000_0000);
        check("t1_valid", 32'(out_valid), 32'd1);
        step();
        check("t1_pc4", out_pc, 32'h4);
        step();
        check("t1_pc8", out_pc, 32'h8);
        check("t1_count", fetch_count, 32'd3);
        check("t1_addr", imem_addr, 32'hC);

        // T2 stall for three cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_pc", out_pc, 32'h8);
            check("t2_instr", out_instr, 32'h1000_0008);
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_addr", imem_addr, 32'hC);
            check("t2_count", fetch_count, 32'd3);
        end
        out_ready = 1'b1;
        step();
        check("t2_resume_pc", out_pc, 32'hC);
        check("t2_resume_count", fetch_count, 32'd4);

        // T3 redirect while a transfer is happening
        redirect_valid  = 1'b1;
        redirect_target = 32'h43;
        step();
        redirect_valid = 1'b0;
        check("t3_flush_valid", 32'(out_valid), 32'd0);
        check("t3_addr", imem_addr, 32'h40);
        check("t3_count", fetch_count, 32'd4);
        step();
        check("t3_pc", out_pc, 32'h40);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_count2", fetch_count, 32'd5);

        // T4 halt at 0x10
        halt_en         = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h10;
        step();
        redirect_valid = 1'b0;
        check("t4_flush_valid", 32'(out_valid), 32'd0);
        step();
        check("t4_instr", out_instr, HALT);
        check("t4_pc", out_pc, 32'h10);
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_addr", imem_addr, 32'h10);
        check("t4_count", fetch_count, 32'd6);
        step();
        check("t4_drain_valid", 32'(out_valid), 32'd0);
        step();
        check("t4_hold_valid", 32'(out_valid), 32'd0);
        check("t4_hold_addr", imem_addr, 32'h10);
        check("t4_hold_count", fetch_count, 32'd6);
        check("t4_hold_halted", 32'(halted), 32'd1);
        halt_en         = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        step();
        redirect_valid = 1'b0;
        check("t4_unhalt", 32'(halted), 32'd0);
        check("t4_re_addr", imem_addr, 32'h80);
        step();
        check("t4_re_pc", out_pc, 32'h80);
        check("t4_re_count", fetch_count, 32'd7);

        // T5 PC wrap
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("t5_pc_top", out_pc, 32'hFFFF_FFFC);
        check("t5_wrap_addr", imem_addr, 32'h0);
        step();
        check("t5_pc_zero", out_pc, 32'h0);
        check("t5_count", fetch_count, 32'd9);

        // T6 async reset during a stall
        out_ready = 1'b0;
        step();
        check("t6_stall_valid", 32'(out_valid), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_count", fetch_count, 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_pc", out_pc, 32'h0);
        step();
        rstN      = 1'b1;
        out_ready = 1'b1;
        step();
        check("t6_boot_valid", 32'(out_valid), 32'd0);
        step();
        check("t6_refetch_pc", out_pc, 32'h0);
        check("t6_refetch_count", fetch_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
